// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        FILTER    = 2'd2,
        RUN       = 2'd3
    } sup_state_e;

    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_LOCK_FILTER    = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 1048576;
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_LOSS_CNT_W     = 8;

    // Width of a counter that runs 0 .. n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// N-stage single-bit synchronizer with a synchronous reset value.
module sync_bit
    import pll_sup_pkg::*;
#(
    parameter int unsigned STAGES  = DEF_SYNC_STAGES,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor in the reference-clock domain.
// Define PLL_AUTORESET_EN to re-pulse pll_rst when lock does not arrive within LOCK_TIMEOUT.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOSS_CNT_W     = DEF_LOSS_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  sys_rst_req,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    input  logic                  loss_clr
);

    localparam int unsigned RST_W = cnt_w(PLL_RST_CYCLES);
    localparam int unsigned FLT_W = cnt_w(LOCK_FILTER);

    localparam logic [RST_W-1:0]      RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [FLT_W-1:0]      FLT_LAST = FLT_W'(LOCK_FILTER - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

    sup_state_e            state_q, state_d;
    logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [FLT_W-1:0]      flt_cnt_q, flt_cnt_d;
    logic                  pll_rst_q, pll_rst_d;
    logic                  sys_rst_req_q, sys_rst_req_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  lk;
    logic                  lk_sync_rst;

`ifdef PLL_AUTORESET_EN
    localparam int unsigned       TMO_W    = cnt_w(LOCK_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    // Without autoreset the timeout has no hardware behind it.
    localparam int unsigned lock_timeout_unused = LOCK_TIMEOUT;
`endif

    // A PLL held in reset reports meaningless lock, so the synchronizer is held clear too.
    assign lk_sync_rst = rst | pll_rst_q;

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (lk_sync_rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = '0;
        flt_cnt_d  = '0;
        loss_cnt_d = loss_cnt_q;
`ifdef PLL_AUTORESET_EN
        tmo_cnt_d  = '0;
`endif

        case (state_q)
            PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = FILTER;
                end
`ifdef PLL_AUTORESET_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = PLL_RST;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            FILTER: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (flt_cnt_q == FLT_LAST) begin
                    state_d = RUN;
                end else begin
                    flt_cnt_d = flt_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    if (loss_cnt_q != LOSS_MAX) begin
                        loss_cnt_d = loss_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (loss_clr) begin
            loss_cnt_d = '0;
        end

        pll_rst_d     = (state_d == PLL_RST);
        sys_rst_req_d = (state_d != RUN);
        ready_d       = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PLL_RST;
            rst_cnt_q     <= '0;
            flt_cnt_q     <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_req_q <= 1'b1;
            ready_q       <= 1'b0;
            loss_cnt_q    <= '0;
`ifdef PLL_AUTORESET_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            flt_cnt_q     <= flt_cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_req_q <= sys_rst_req_d;
            ready_q       <= ready_d;
            loss_cnt_q    <= loss_cnt_d;
`ifdef PLL_AUTORESET_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_req = sys_rst_req_q;
    assign ready       = ready_q;
    assign loss_cnt    = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: timed expectations go into a scoreboard
// queue and are compared on the falling edge of the cycle they fall due.
module tb_pll_lock_supervisor;

    localparam int unsigned LF  = 64;
    localparam int unsigned LT  = 64;
    localparam int unsigned PRC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       loss_clr;
    logic       pll_rst;
    logic       sys_rst_req;
    logic       ready;
    logic [7:0] loss_cnt;

    pll_lock_supervisor #(
        .SYNC_STAGES    (2),
        .LOCK_FILTER    (LF),
        .LOCK_TIMEOUT   (LT),
        .PLL_RST_CYCLES (PRC),
        .LOSS_CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst_req (sys_rst_req),
        .ready       (ready),
        .loss_cnt    (loss_cnt),
        .loss_clr    (loss_clr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mask bits: [3] pll_rst, [2] sys_rst_req, [1] ready, [0] loss_cnt
    typedef struct {
        string       name;
        int unsigned due;
        logic [3:0]  mask;
        logic        prst;
        logic        srr;
        logic        rdy;
        logic [7:0]  loss;
    } exp_t;

    typedef struct {
        int unsigned low;
        logic        pre_clr;
        logic        co_clr;
        logic [7:0]  exp_loss;
    } vec_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] cur_loss = 8'd0;
    vec_t       vecs[6];

    function automatic void sb_push(input string name, input int unsigned due, input logic [3:0] mask,
                                    input logic prst, input logic srr, input logic rdy, input logic [7:0] loss);
        exp_t e;
        e.name = name; e.due = due; e.mask = mask;
        e.prst = prst; e.srr = srr; e.rdy = rdy; e.loss = loss;
        sb_q.push_back(e);
    endfunction

    task automatic sb_check(input exp_t e);
        logic ok;
        ok = (e.due == cyc)
           && (!e.mask[3] || (pll_rst === e.prst))
           && (!e.mask[2] || (sys_rst_req === e.srr))
           && (!e.mask[1] || (ready === e.rdy))
           && (!e.mask[0] || (loss_cnt === e.loss));
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d (due %0d): got pll_rst=%b sys_rst_req=%b ready=%b loss_cnt=%0d, want pll_rst=%b sys_rst_req=%b ready=%b loss_cnt=%0d (mask %b)",
                     e.name, cyc, e.due, pll_rst, sys_rst_req, ready, loss_cnt,
                     e.prst, e.srr, e.rdy, e.loss, e.mask);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                exp_t e;
                e = sb_q[i];
                sb_q.delete(i);
                sb_check(e);
            end
        end
    end

    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts and ends in RUN; lk stays low for v.low cycles.
    task automatic loss_event(input vec_t v);
        int unsigned k;
        if (v.pre_clr) begin
            k = cyc;
            loss_clr = 1'b1;
            sb_push("pre_clr", k + 1, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0);
            wait_until(k + 1);
            loss_clr = 1'b0;
            cur_loss = 8'd0;
            wait_until(k + 2);
        end
        k = cyc;
        pll_locked = 1'b0;
        sb_push("loss_hold",   k + 2,              4'b0111, 1'b0, 1'b0, 1'b1, cur_loss);
        sb_push("loss_detect", k + 3,              4'b1111, 1'b0, 1'b1, 1'b0, v.exp_loss);
        sb_push("relock_pre",  k + v.low + 2 + LF, 4'b0110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("relock",      k + v.low + 3 + LF, 4'b1111, 1'b0, 1'b0, 1'b1, v.exp_loss);
        wait_until(k + 2);
        loss_clr = v.co_clr;
        wait_until(k + 3);
        loss_clr = 1'b0;
        wait_until(k + v.low);
        pll_locked = 1'b1;
        wait_until(k + v.low + 4 + LF);
        cur_loss = v.exp_loss;
    endtask

    initial begin
        int unsigned c0;
        int unsigned k;
        int unsigned f;
        int unsigned g;
        int unsigned r;
        vec_t        v;

        vecs[0] = '{low: 3, pre_clr: 1'b0, co_clr: 1'b0, exp_loss: 8'd2};
        vecs[1] = '{low: 3, pre_clr: 1'b0, co_clr: 1'b0, exp_loss: 8'd3};
        vecs[2] = '{low: 3, pre_clr: 1'b0, co_clr: 1'b0, exp_loss: 8'd4};
        vecs[3] = '{low: 4, pre_clr: 1'b1, co_clr: 1'b0, exp_loss: 8'd1};
        vecs[4] = '{low: 6, pre_clr: 1'b0, co_clr: 1'b1, exp_loss: 8'd0};
        vecs[5] = '{low: 3, pre_clr: 1'b0, co_clr: 1'b0, exp_loss: 8'd1};

        // Power-up with pll_locked tied high.
        rst        = 1'b1;
        pll_locked = 1'b1;
        loss_clr   = 1'b0;
        sb_push("in_reset", 2, 4'b1111, 1'b1, 1'b1, 1'b0, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        c0  = cyc;
        sb_push("reset_state",  c0,           4'b1111, 1'b1, 1'b1, 1'b0, 8'd0);
        sb_push("pll_rst_mid",  c0 + 8,       4'b1000, 1'b1, 1'b0, 1'b0, 8'd0);
        sb_push("pll_rst_last", c0 + PRC - 1, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd0);
        sb_push("pll_rst_fall", c0 + PRC,     4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("ready_pre",    c0 + PRC + 2 + LF, 4'b0110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("ready_rise",   c0 + PRC + 3 + LF, 4'b1111, 1'b0, 1'b0, 1'b1, 8'd0);
        wait_until(c0 + PRC + 4 + LF);

        // Loss in RUN, then a one-cycle glitch about halfway through the filter window.
        k = cyc;
        pll_locked = 1'b0;
        sb_push("glitch_loss", k + 3, 4'b1111, 1'b0, 1'b1, 1'b0, 8'd1);
        f = k + 6;
        g = f + 30;
        sb_push("glitch_no_early", f + LF,     4'b0110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("glitch_pre",      g + 3 + LF, 4'b0110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("glitch_ready",    g + 4 + LF, 4'b1111, 1'b0, 1'b0, 1'b1, 8'd1);
        wait_until(k + 3);
        pll_locked = 1'b1;
        wait_until(g);
        pll_locked = 1'b0;
        wait_until(g + 1);
        pll_locked = 1'b1;
        wait_until(g + 5 + LF);
        cur_loss = 8'd1;

        // Table of loss events.
        for (int i = 0; i < 6; i++) begin
            loss_event(vecs[i]);
        end

        // Saturation: 300 losses from a cleared count, then a clear coincident with a loss.
        for (int i = 1; i <= 300; i++) begin
            v.low      = 3;
            v.pre_clr  = (i == 1);
            v.co_clr   = 1'b0;
            v.exp_loss = (i >= 255) ? 8'd255 : 8'(i);
            loss_event(v);
        end
        v = '{low: 3, pre_clr: 1'b0, co_clr: 1'b1, exp_loss: 8'd0};
        loss_event(v);
        v = '{low: 5, pre_clr: 1'b0, co_clr: 1'b0, exp_loss: 8'd1};
        loss_event(v);

        // Mid-operation reset from RUN, then pll_locked held low.
        r = cyc;
        rst        = 1'b1;
        pll_locked = 1'b0;
        sb_push("midrst_before", r,     4'b1111, 1'b0, 1'b0, 1'b1, 8'd1);
        sb_push("midrst",        r + 1, 4'b1111, 1'b1, 1'b1, 1'b0, 8'd0);
        wait_until(r + 1);
        rst = 1'b0;
        c0  = cyc;
        sb_push("to_pll_rst_last", c0 + PRC - 1, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd0);
        sb_push("to_pll_rst_fall", c0 + PRC,     4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
`ifdef PLL_AUTORESET_EN
        for (int p = 1; p <= 2; p++) begin
            sb_push("to_gap_end",   c0 + p*(LT + PRC) - 1,   4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
            sb_push("to_pulse_on",  c0 + p*(LT + PRC),       4'b1110, 1'b1, 1'b1, 1'b0, 8'd0);
            sb_push("to_pulse_end", c0 + p*(LT + PRC) + PRC - 1, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd0);
            sb_push("to_pulse_off", c0 + p*(LT + PRC) + PRC, 4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
        end
`else
        sb_push("no_retry_a", c0 + LT + PRC,           4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("no_retry_b", c0 + LT + 2*PRC - 1,     4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("no_retry_c", c0 + 2*(LT + PRC),       4'b1110, 1'b0, 1'b1, 1'b0, 8'd0);
        sb_push("no_retry_d", c0 + 3*(LT + PRC),       4'b1111, 1'b0, 1'b1, 1'b0, 8'd0);
`endif
        wait_until(c0 + 3*(LT + PRC) + 2);

        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
